rx_frame_ctrl: RTL and testbench
================================

Name: rx_frame_ctrl

Overview:
- Receive-side frame sequencer for the BPSK receive chain.
- Sits downstream of packet detection and boundary detection. It configures the boundary-detect window, waits for bit-boundary lock, and recovers the corrected bit stream.
- Parses an MSB-first length header, gates payload bits out with a valid strobe, then tells boundary detection to release via disassert_BD.
- Frame loss is handled by a lock timeout and by PD_flag dropping mid-frame.

Parameters:
- MAX_WINDOW_WIDTH, 8, width of the boundary-detect window value.
- LEN_WIDTH, 8, bits in the header length field; maximum payload is 2^LEN_WIDTH-1 bits.
- TIMEOUT_WIDTH, 12, width of the lock-timeout counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- clk_enable  in  1  symbol strobe; state and outputs advance only on clk edges with clk_enable=1.
- cfg_window  in  MAX_WINDOW_WIDTH  requested boundary-detect window.
- cfg_timeout  in  TIMEOUT_WIDTH  enabled cycles allowed in SEARCH before abort; 0 disables the timeout.
- PD_flag  in  1  packet-detected level.
- BD_flag  in  1  boundary lock level.
- BD_sgn  in  1  phase sign at lock; 0 means 180° phase bias.
- bit_in  in  1  hard-decided BPSK bit.
- RX_BD_WINDOW  out  MAX_WINDOW_WIDTH  window driven to boundary detection.
- disassert_BD  out  1  release request to boundary detection.
- bit_out  out  1  phase-corrected payload bit.
- bit_vld  out  1  bit_out valid.
- frame_len  out  LEN_WIDTH  parsed payload length.
- frame_start  out  1  pulse: header parsed, payload follows.
- frame_done  out  1  pulse: payload complete.
- frame_err  out  1  pulse: timeout, zero length, or PD loss.
- busy  out  1  state is not IDLE.

Behaviour:
- Async reset values:
  - state=IDLE, RX_BD_WINDOW=8 (saturated to 2^MAX_WINDOW_WIDTH-1 if narrower).
  - All other outputs 0; counters and latched sign 0.
- All outputs are registered and change only on enabled edges. A "pulse" is high for exactly one enabled cycle and holds across disabled clocks.
- Corrected bit: cb = bit_in XOR ~sgn_q, where sgn_q is BD_sgn latched at lock.
- IDLE:
  - On PD_flag=1: latch RX_BD_WINDOW = max(cfg_window, 2), clear tcnt, go to SEARCH.
  - cfg_window may change at any time; it is sampled only at this transition.
- SEARCH:
  - PD_flag=0 → IDLE, no error.
  - Else BD_flag=1 → latch sgn_q=BD_sgn, clear bcnt and frame_len, go to HDR.
  - Else tcnt++. When cfg_timeout≠0 and tcnt==cfg_timeout-1 → ABORT.
  - BD_flag takes priority over timeout in the same cycle.
- HDR:
  - frame_len <= {frame_len[LEN_WIDTH-2:0], cb}, bcnt++.
  - On the LEN_WIDTH-th bit: if the assembled length is 0 → ABORT. Otherwise pulse frame_start, clear bcnt, go to PAYLOAD.
  - PD_flag=0 in any HDR cycle → ABORT; that bit is not shifted in.
- PAYLOAD:
  - bit_out=cb and bit_vld=1 on each enabled cycle, registered one cycle after sampling.
  - bcnt++; on bit number frame_len (bcnt==frame_len-1) → DONE.
  - PD_flag=0 → ABORT; no bit_vld that cycle.
  - bit_vld is 0 in all other states.
- DONE: pulse frame_done, go to WAIT.
- ABORT: pulse frame_err, go to WAIT.
- WAIT:
  - disassert_BD=1 on the edges entering and while in DONE, ABORT and WAIT; 0 elsewhere.
  - Stay until PD_flag=0, then → IDLE on the next enabled edge. This prevents re-locking on the tail of the same frame.
- frame_len holds its value until the next HDR entry.
- Reset mid-frame returns to IDLE immediately, with no pulses emitted.
- Arithmetic: tcnt is TIMEOUT_WIDTH bits, bcnt is LEN_WIDTH bits, no wrap.
- State encoding (3 bits): IDLE 0, SEARCH 1, HDR 2, PAYLOAD 3, DONE 4, ABORT 5, WAIT 6. Value 7 → IDLE.

Test Plan:
- Nominal frame:
  - Stimulus: clk_enable=1, cfg_window=4; PD_flag rises; BD_flag rises 10 cycles later with BD_sgn=1. Header 0x05, then payload 10110.
  - Required: RX_BD_WINDOW=4, frame_len=5, frame_start once, 5 bit_vld with 1,0,1,1,0, frame_done once, disassert_BD high until PD_flag falls, then busy=0.
- Inverted phase:
  - Stimulus: same frame with BD_sgn=0 and all bit_in inverted.
  - Required: identical frame_len=5 and payload 10110.
- Lock timeout:
  - Stimulus: cfg_timeout=16, PD_flag=1, BD_flag never asserts.
  - Required: frame_err pulse after exactly 16 enabled cycles in SEARCH; cfg_timeout=0 never times out.
- PD loss mid-payload:
  - Stimulus: header 0x20, PD_flag drops after 7 payload bits.
  - Required: 7 bit_vld, frame_err pulse, no frame_done, return to IDLE.
- Zero length and window clamp:
  - Stimulus: cfg_window=1; header 0x00.
  - Required: RX_BD_WINDOW=2; frame_err pulse, no frame_start.
- Throttled enable and async reset:
  - Stimulus: clk_enable high 1 cycle in 3 on the nominal frame; rst_n low mid-PAYLOAD.
  - Required: same bit sequence, pulses each spanning 3 clocks; all outputs reset immediately, asynchronously.

Source files
------------

// File: rtl/rx_frame_ctrl.sv
// Receive-side frame sequencer: arms boundary detection, waits for lock, parses an
// MSB-first length header and strobes the phase-corrected payload bits out.
module rx_frame_ctrl #(
  parameter int MAX_WINDOW_WIDTH = 8,
  parameter int LEN_WIDTH        = 8,
  parameter int TIMEOUT_WIDTH    = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_enable,
  input  logic [MAX_WINDOW_WIDTH-1:0] cfg_window,
  input  logic [TIMEOUT_WIDTH-1:0]    cfg_timeout,
  input  logic                        PD_flag,
  input  logic                        BD_flag,
  input  logic                        BD_sgn,
  input  logic                        bit_in,
  output logic [MAX_WINDOW_WIDTH-1:0] RX_BD_WINDOW,
  output logic                        disassert_BD,
  output logic                        bit_out,
  output logic                        bit_vld,
  output logic [LEN_WIDTH-1:0]        frame_len,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        frame_err,
  output logic                        busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEARCH  = 3'd1,
    S_HDR     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4,
    S_ABORT   = 3'd5,
    S_WAIT    = 3'd6
  } state_e;

  // Default window is 8, saturated when the window field cannot hold 8.
  localparam logic [MAX_WINDOW_WIDTH-1:0] WIN_RESET =
    (MAX_WINDOW_WIDTH >= 4) ? MAX_WINDOW_WIDTH'(8) : {MAX_WINDOW_WIDTH{1'b1}};
  localparam logic [MAX_WINDOW_WIDTH-1:0] WIN_MIN =
    (MAX_WINDOW_WIDTH >= 2) ? MAX_WINDOW_WIDTH'(2) : {MAX_WINDOW_WIDTH{1'b1}};
  localparam logic [LEN_WIDTH-1:0] HDR_LAST = LEN_WIDTH'(LEN_WIDTH - 1);

  state_e                      state_q, state_d;
  logic [MAX_WINDOW_WIDTH-1:0] win_q, win_d;
  logic [TIMEOUT_WIDTH-1:0]    tcnt_q, tcnt_d;
  logic [LEN_WIDTH-1:0]        bcnt_q, bcnt_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d;
  logic                        sgn_q, sgn_d;
  logic                        bit_out_q, bit_out_d;
  logic                        bit_vld_q, bit_vld_d;
  logic                        start_q, start_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        disassert_q, disassert_d;
  logic                        busy_q, busy_d;

  logic                        cb;
  logic [LEN_WIDTH-1:0]        len_shift;

  // sgn_q = 0 marks a 180-degree lock, so the received bit is flipped back.
  assign cb        = bit_in ^ ~sgn_q;
  assign len_shift = {len_q[LEN_WIDTH-2:0], cb};

  always_comb begin
    // NOTE: every variable gets a default before the case so no path infers a latch.
    state_d   = state_q;
    win_d     = win_q;
    tcnt_d    = tcnt_q;
    bcnt_d    = bcnt_q;
    len_d     = len_q;
    sgn_d     = sgn_q;
    bit_out_d = bit_out_q;
    bit_vld_d = 1'b0;
    start_d   = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (PD_flag) begin
          win_d   = (cfg_window < WIN_MIN) ? WIN_MIN : cfg_window;
          tcnt_d  = '0;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (!PD_flag) begin
          state_d = S_IDLE;
        end else if (BD_flag) begin
          sgn_d   = BD_sgn;
          bcnt_d  = '0;
          len_d   = '0;
          state_d = S_HDR;
        end else begin
          if (tcnt_q != '1) tcnt_d = tcnt_q + TIMEOUT_WIDTH'(1);
          if (cfg_timeout != '0 && tcnt_q == cfg_timeout - TIMEOUT_WIDTH'(1))
            state_d = S_ABORT;
        end
      end
      S_HDR: begin
        if (!PD_flag) begin
          state_d = S_ABORT;
        end else begin
          len_d  = len_shift;
          bcnt_d = bcnt_q + LEN_WIDTH'(1);
          if (bcnt_q == HDR_LAST) begin
            if (len_shift == '0) begin
              state_d = S_ABORT;
            end else begin
              start_d = 1'b1;
              bcnt_d  = '0;
              state_d = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (!PD_flag) begin
          state_d = S_ABORT;
        end else begin
          bit_out_d = cb;
          bit_vld_d = 1'b1;
          if (bcnt_q != '1) bcnt_d = bcnt_q + LEN_WIDTH'(1);
          if (bcnt_q == len_q - LEN_WIDTH'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_WAIT;
      end
      S_ABORT: begin
        err_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Holding here until PD drops keeps us from re-locking on the frame tail.
        if (!PD_flag) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    disassert_d = (state_d == S_DONE) || (state_d == S_ABORT) || (state_d == S_WAIT);
    busy_d      = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      win_q       <= WIN_RESET;
      tcnt_q      <= '0;
      bcnt_q      <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_vld_q   <= 1'b0;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      disassert_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (clk_enable) begin
      state_q     <= state_d;
      win_q       <= win_d;
      tcnt_q      <= tcnt_d;
      bcnt_q      <= bcnt_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      bit_out_q   <= bit_out_d;
      bit_vld_q   <= bit_vld_d;
      start_q     <= start_d;
      done_q      <= done_d;
      err_q       <= err_d;
      disassert_q <= disassert_d;
      busy_q      <= busy_d;
    end
  end

  assign RX_BD_WINDOW = win_q;
  assign disassert_BD = disassert_q;
  assign bit_out      = bit_out_q;
  assign bit_vld      = bit_vld_q;
  assign frame_len    = len_q;
  assign frame_start  = start_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl: nominal, inverted, timeout, PD loss, zero length,
// throttled enable and asynchronous reset, with hand-computed expectations.
module tb_rx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_enable;
  logic [7:0]  cfg_window;
  logic [11:0] cfg_timeout;
  logic        PD_flag, BD_flag, BD_sgn, bit_in;
  logic [7:0]  RX_BD_WINDOW;
  logic        disassert_BD, bit_out, bit_vld;
  logic [7:0]  frame_len;
  logic        frame_start, frame_done, frame_err, busy;

  rx_frame_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .cfg_window   (cfg_window),
    .cfg_timeout  (cfg_timeout),
    .PD_flag      (PD_flag),
    .BD_flag      (BD_flag),
    .BD_sgn       (BD_sgn),
    .bit_in       (bit_in),
    .RX_BD_WINDOW (RX_BD_WINDOW),
    .disassert_BD (disassert_BD),
    .bit_out      (bit_out),
    .bit_vld      (bit_vld),
    .frame_len    (frame_len),
    .frame_start  (frame_start),
    .frame_done   (frame_done),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          throttle = 1'b0;
  int          start_clks, done_clks, err_clks, vld_clks, rx_n;
  logic [63:0] rx_bits;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    start_clks = 0; done_clks = 0; err_clks = 0; vld_clks = 0; rx_n = 0; rx_bits = '0;
  endtask

  task automatic sample(input bit first);
    if (frame_start) start_clks++;
    if (frame_done)  done_clks++;
    if (frame_err)   err_clks++;
    if (bit_vld) begin
      vld_clks++;
      if (first) begin
        rx_bits = {rx_bits[62:0], bit_out};
        rx_n++;
      end
    end
  endtask

  // One enabled cycle; when throttled the enable is followed by two idle clocks.
  task automatic en_cycle();
    clk_enable = 1'b1;
    @(posedge clk); #1; sample(1'b1);
    if (throttle) begin
      clk_enable = 1'b0;
      repeat (2) begin @(posedge clk); #1; sample(1'b0); end
    end
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input bit inv);
    for (int i = n - 1; i >= 0; i--) begin
      bit_in = v[i] ^ inv;
      en_cycle();
    end
  endtask

  task automatic start_frame(input logic [7:0] win, input logic [7:0] exp_win,
                             input int lock_delay, input bit sgn, input string tag);
    cfg_window = win;
    PD_flag = 1'b1; BD_flag = 1'b0;
    en_cycle();
    check({tag, " window"}, RX_BD_WINDOW, exp_win);
    check({tag, " busy in search"}, busy, 1'b1);
    cfg_window = 8'hAA;
    repeat (lock_delay - 1) en_cycle();
    BD_flag = 1'b1; BD_sgn = sgn;
    en_cycle();
    BD_flag = 1'b0;
  endtask

  task automatic run_nominal(input bit sgn, input string tag);
    int span;
    span = throttle ? 3 : 1;
    clear_stats();
    start_frame(8'd4, 8'd4, 10, sgn, tag);
    send_bits(64'h05, 8, ~sgn);
    check({tag, " frame_len"}, frame_len, 8'd5);
    check({tag, " start span"}, start_clks, span);
    send_bits(64'b10110, 5, ~sgn);
    en_cycle();
    en_cycle();
    check({tag, " disassert in wait"}, disassert_BD, 1'b1);
    check({tag, " done span"}, done_clks, span);
    check({tag, " bit count"}, rx_n, 5);
    check({tag, " bits"}, rx_bits, 64'b10110);
    check({tag, " vld clocks"}, vld_clks, 5 * span);
    PD_flag = 1'b0;
    en_cycle();
    check({tag, " idle busy"}, busy, 1'b0);
    check({tag, " idle disassert"}, disassert_BD, 1'b0);
    check({tag, " no err"}, err_clks, 0);
  endtask

  initial begin
    rst_n = 1'b0; clk_enable = 1'b1; cfg_window = 8'd0; cfg_timeout = 12'd100;
    PD_flag = 1'b0; BD_flag = 1'b0; BD_sgn = 1'b0; bit_in = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check("reset window", RX_BD_WINDOW, 8'd8);
    check("reset busy", busy, 1'b0);
    check("reset disassert", disassert_BD, 1'b0);
    check("reset frame_len", frame_len, 8'd0);
    check("reset outputs", {bit_out, bit_vld, frame_start, frame_done, frame_err}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_nominal(1'b1, "nominal");
    run_nominal(1'b0, "inverted");

    // Lock timeout: abort on the 16th enabled SEARCH cycle, err pulse the cycle after.
    clear_stats();
    cfg_timeout = 12'd16; PD_flag = 1'b1; BD_flag = 1'b0;
    en_cycle();
    repeat (15) en_cycle();
    check("timeout not yet", disassert_BD, 1'b0);
    en_cycle();
    check("timeout abort", disassert_BD, 1'b1);
    check("timeout err not yet", err_clks, 0);
    en_cycle();
    check("timeout err pulse", frame_err, 1'b1);
    PD_flag = 1'b0;
    en_cycle();
    check("timeout idle", busy, 1'b0);

    // cfg_timeout = 0 never aborts.
    clear_stats();
    cfg_timeout = 12'd0; PD_flag = 1'b1;
    repeat (200) en_cycle();
    check("no-timeout err", err_clks, 0);
    check("no-timeout busy", busy, 1'b1);
    check("no-timeout disassert", disassert_BD, 1'b0);
    PD_flag = 1'b0;
    en_cycle();
    cfg_timeout = 12'd100;

    // PD loss after 7 payload bits of a 32-bit frame.
    clear_stats();
    start_frame(8'd4, 8'd4, 3, 1'b1, "pdloss");
    send_bits(64'h20, 8, 1'b0);
    send_bits(64'b1100101, 7, 1'b0);
    PD_flag = 1'b0;
    en_cycle();
    check("pdloss no vld on drop", bit_vld, 1'b0);
    en_cycle();
    en_cycle();
    en_cycle();
    check("pdloss bit count", rx_n, 7);
    check("pdloss bits", rx_bits, 64'b1100101);
    check("pdloss err", err_clks, 1);
    check("pdloss no done", done_clks, 0);
    check("pdloss idle", busy, 1'b0);
    check("pdloss frame_len", frame_len, 8'd32);

    // Zero length header with a clamped window.
    clear_stats();
    start_frame(8'd1, 8'd2, 2, 1'b1, "zerolen");
    send_bits(64'h00, 8, 1'b0);
    en_cycle();
    check("zerolen err pulse", frame_err, 1'b1);
    PD_flag = 1'b0;
    en_cycle();
    en_cycle();
    check("zerolen no start", start_clks, 0);
    check("zerolen err count", err_clks, 1);
    check("zerolen idle", busy, 1'b0);

    // Throttled enable: same frame, each pulse spans three clocks.
    throttle = 1'b1;
    run_nominal(1'b1, "throttled");

    // Asynchronous reset in the middle of a throttled payload.
    clear_stats();
    start_frame(8'd4, 8'd4, 10, 1'b1, "rstmid");
    send_bits(64'h05, 8, 1'b0);
    send_bits(64'b101, 3, 1'b0);
    check("rstmid vld before reset", bit_vld, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rstmid busy", busy, 1'b0);
    check("rstmid vld", bit_vld, 1'b0);
    check("rstmid window", RX_BD_WINDOW, 8'd8);
    check("rstmid frame_len", frame_len, 8'd0);
    check("rstmid flags", {disassert_BD, frame_start, frame_done, frame_err}, 4'b0);
    PD_flag = 1'b0;
    #10 rst_n = 1'b1;
    clear_stats();
    throttle = 1'b0;
    repeat (4) en_cycle();
    check("rstmid no pulses", start_clks + done_clks + err_clks + vld_clks, 0);
    check("rstmid stays idle", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
